// File: rtl/timing_generator.sv
// 6502 T-state sequencer: runs the 7-cycle reset sequence, flags opcode fetch, tracks overruns.
// Optional TIMING_STALL_CNT_EN adds a saturating count of rdy-stalled cycles on stall_cnt.
module timing_generator #(
  parameter int unsigned TMAX = 7
) (
  input  logic       clk_2,
  input  logic       res_n,
  input  logic       rdy,
  input  logic       end_instr,
  output logic [2:0] tcyc,
  output logic [6:0] t_onehot,
  output logic       sync,
  output logic       rst_seq,
`ifdef TIMING_STALL_CNT_EN
  output logic [7:0] stall_cnt,
`endif
  output logic       t_ovf
);

  localparam logic [2:0] TLast = 3'(TMAX);

  logic [2:0] tcyc_q, tcyc_d;
  logic       rst_seq_q, rst_seq_d;
  logic       t_ovf_q, t_ovf_d;

  always_comb begin
    tcyc_d    = tcyc_q;
    rst_seq_d = rst_seq_q;
    t_ovf_d   = t_ovf_q;
    if (rdy) begin
      if (rst_seq_q) begin
        // end_instr is ignored while the reset sequence runs.
        if (tcyc_q == TLast) begin
          tcyc_d    = 3'd1;
          rst_seq_d = 1'b0;
        end else begin
          tcyc_d = tcyc_q + 3'd1;
        end
      end else if (tcyc_q == 3'd1) begin
        tcyc_d = 3'd2;
      end else if (end_instr) begin
        tcyc_d = 3'd1;
      end else if (tcyc_q == TLast) begin
        tcyc_d  = 3'd1;
        t_ovf_d = 1'b1;
      end else begin
        tcyc_d = tcyc_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_2 or negedge res_n) begin
    if (!res_n) begin
      tcyc_q    <= 3'd1;
      rst_seq_q <= 1'b1;
      t_ovf_q   <= 1'b0;
    end else begin
      tcyc_q    <= tcyc_d;
      rst_seq_q <= rst_seq_d;
      t_ovf_q   <= t_ovf_d;
    end
  end

`ifdef TIMING_STALL_CNT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!rdy && (stall_cnt_q != 8'hFF)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_2 or negedge res_n) begin
    if (!res_n) begin
      stall_cnt_q <= 8'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  // Outputs decode only registered state, never the inputs.
  assign tcyc     = tcyc_q;
  assign t_onehot = 7'b0000001 << (tcyc_q - 3'd1);
  assign sync     = (tcyc_q == 3'd1) && !rst_seq_q;
  assign rst_seq  = rst_seq_q;
  assign t_ovf    = t_ovf_q;

endmodule

// File: tb/tb_timing_generator.sv
// Directed bench for timing_generator: a reference model queues expected state per edge,
// which is popped and compared one time unit after each rising clk_2.
module tb_timing_generator;

  logic       clk_2 = 1'b0;
  logic       res_n = 1'b0;
  logic       rdy = 1'b1;
  logic       end_instr = 1'b0;
  logic [2:0] tcyc;
  logic [6:0] t_onehot;
  logic       sync;
  logic       rst_seq;
  logic       t_ovf;
`ifdef TIMING_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  timing_generator #(.TMAX(7)) dut (
    .clk_2     (clk_2),
    .res_n     (res_n),
    .rdy       (rdy),
    .end_instr (end_instr),
    .tcyc      (tcyc),
    .t_onehot  (t_onehot),
    .sync      (sync),
    .rst_seq   (rst_seq),
`ifdef TIMING_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .t_ovf     (t_ovf)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    logic [2:0] tcyc;
    logic [6:0] onehot;
    logic       sync;
    logic       rst_seq;
    logic       ovf;
    logic [7:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model state
  int   m_t = 1;
  bit   m_rst = 1'b1;
  bit   m_ovf = 1'b0;
  int   m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.tcyc = 3'(m_t);
    e.onehot = '0;
    for (int i = 0; i < 7; i++) e.onehot[i] = (m_t == i + 1);
    e.sync = (m_t == 1) && !m_rst;
    e.rst_seq = m_rst;
    e.ovf = m_ovf;
    e.stall = 8'(m_stall);
    return e;
  endfunction

  task automatic model_reset();
    m_t = 1; m_rst = 1'b1; m_ovf = 1'b0; m_stall = 0;
  endtask

  task automatic model_edge(input bit r, input bit e);
    if (!r) begin
      if (m_stall < 255) m_stall++;
    end else if (m_rst) begin
      if (m_t == 7) begin m_t = 1; m_rst = 1'b0; end
      else m_t++;
    end else if (m_t == 1) begin
      m_t = 2;
    end else if (e) begin
      m_t = 1;
    end else if (m_t == 7) begin
      m_t = 1; m_ovf = 1'b1;
    end else begin
      m_t++;
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_tcyc"}, 32'(tcyc), 32'(e.tcyc));
    check({tag, "_onehot"}, 32'(t_onehot), 32'(e.onehot));
    check({tag, "_sync"}, 32'(sync), 32'(e.sync));
    check({tag, "_rst_seq"}, 32'(rst_seq), 32'(e.rst_seq));
    check({tag, "_t_ovf"}, 32'(t_ovf), 32'(e.ovf));
`ifdef TIMING_STALL_CNT_EN
    check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(e.stall));
`endif
  endtask

  // Drive inputs away from the edge, push the expected post-edge state, then compare.
  task automatic step(input string tag, input bit r, input bit e);
    rdy = r;
    end_instr = e;
    model_edge(r, e);
    exp_q.push_back(model_snapshot());
    @(posedge clk_2);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held across edges: state must hold.
    res_n = 1'b0; rdy = 1'b1; end_instr = 1'b1;
    repeat (2) @(posedge clk_2);
    #1;
    check("reset_tcyc", 32'(tcyc), 32'd1);
    check("reset_onehot", 32'(t_onehot), 32'h01);
    check("reset_rst_seq", 32'(rst_seq), 32'd1);
    check("reset_sync", 32'(sync), 32'd0);
    check("reset_t_ovf", 32'(t_ovf), 32'd0);
`ifdef TIMING_STALL_CNT_EN
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    #2 res_n = 1'b1;

    for (int i = 0; i < 7; i++) step("rstseq", 1'b1, 1'b0);
    check("first_sync", 32'(sync), 32'd1);
    check("first_sync_tcyc", 32'(tcyc), 32'd1);

    for (int i = 0; i < 3; i++) begin
      step("two_cyc_t2", 1'b1, 1'b0);
      step("two_cyc_t1", 1'b1, 1'b1);
    end

    step("to_t2", 1'b1, 1'b0);
    step("to_t3", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("stall_t3", 1'b0, 1'b1);
    step("after_stall", 1'b1, 1'b0);
    check("after_stall_t4", 32'(tcyc), 32'd4);
`ifdef TIMING_STALL_CNT_EN
    check("stall_cnt_4", 32'(stall_cnt), 32'd4);
`endif
    step("end_at_t4", 1'b1, 1'b1);

    step("end_at_t1_ignored", 1'b1, 1'b1);
    check("end_at_t1_tcyc", 32'(tcyc), 32'd2);
    step("end_at_t2", 1'b1, 1'b1);

    // Stall during T1 keeps sync high.
    step("stall_t1", 1'b0, 1'b0);
    check("stall_t1_sync", 32'(sync), 32'd1);

    for (int i = 0; i < 7; i++) step("overrun", 1'b1, 1'b0);
    check("overrun_ovf", 32'(t_ovf), 32'd1);
    check("overrun_wrap", 32'(tcyc), 32'd1);
    step("sticky_t2", 1'b1, 1'b0);
    step("sticky_t1", 1'b1, 1'b1);

    for (int i = 0; i < 4; i++) step("to_t5", 1'b1, 1'b0);
    check("at_t5", 32'(tcyc), 32'd5);
    #2 res_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_snapshot());
    compare_outputs("async_reset");
    rdy = 1'b1; end_instr = 1'b0;
    @(posedge clk_2);
    #1;
    exp_q.push_back(model_snapshot());
    compare_outputs("reset_hold");
    #2 res_n = 1'b1;

    for (int i = 0; i < 7; i++) step("rstseq2", 1'b1, 1'b0);
    check("second_sync", 32'(sync), 32'd1);

`ifdef TIMING_STALL_CNT_EN
    for (int i = 0; i < 300; i++) step("long_stall", 1'b0, 1'b0);
    check("stall_saturate", 32'(stall_cnt), 32'd255);
`else
    for (int i = 0; i < 20; i++) step("long_stall", 1'b0, 1'b0);
`endif
    check("stall_hold_tcyc", 32'(tcyc), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
